// File: rtl/dmem_bus_bridge_pkg.sv
// Shared types and constants for the MEM-stage data-memory bus bridge.
// Also carries the access-size codes and trap cause codes for the load/store path.
package dmem_bus_bridge_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_e;

  // Funct3 access-size codes
  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTEU = 3'b100;
  localparam logic [2:0] F3_HALFU = 3'b101;

  // Exception cause codes handed to the trap logic
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED   = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_ACCESS_FAULT = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED  = 4'd6;
  localparam logic [3:0] CAUSE_STORE_ACCESS_FAULT = 4'd7;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [STRB_W-1:0] wstrb;
    logic [XLEN-1:0]   wdata;
    logic              read;
  } dmem_req_t;

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] byte_addr);
    return {byte_addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_align_check.sv
// Combinational size/offset misalignment detector for data-memory accesses.
module dmem_align_check
  import dmem_bus_bridge_pkg::*;
(
  input  logic       access_i,
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  output logic       misaligned_o
);

  logic size_mis;

  always_comb begin
    size_mis = 1'b0;
    case (funct3_i)
      F3_HALF, F3_HALFU: size_mis = addr_lo_i[0];
      F3_WORD:           size_mis = |addr_lo_i;
      default:           size_mis = 1'b0;
    endcase
  end

  assign misaligned_o = access_i & size_mis;

endmodule

// File: rtl/dmem_bus_bridge.sv
// MEM-stage bridge: one valid/ready bus transaction per load/store, pipeline stall
// until the response, misalignment and timeout detection.
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemReadM,
  input  logic [3:0]  MemWriteMaskM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataAlignedM,
  input  logic        FlushM,
  output logic        StallMem,
  output logic [31:0] ReadDataRaw,
  output logic        LoadValidM,
  output logic        MisalignedM,
  output logic        BusErrorM,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dmem_state_e      state_q, state_d;
  dmem_req_t        req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kill_q, kill_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic access;
  logic misaligned;
  logic kill_now;
  logic timeout_hit;
  logic stall_c, req_valid_c, load_valid_c, misaligned_c, bus_error_c;

  assign access      = MemReadM | (|MemWriteMaskM);
  assign kill_now    = kill_q | FlushM;
  assign timeout_hit = (cnt_q >= TO_LAST);

  dmem_align_check u_align (
    .access_i     (access),
    .funct3_i     (Funct3M),
    .addr_lo_i    (AddrM[1:0]),
    .misaligned_o (misaligned)
  );

  // State and request registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    kill_d       = kill_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    stall_c      = 1'b0;
    req_valid_c  = 1'b0;
    load_valid_c = 1'b0;
    misaligned_c = 1'b0;
    bus_error_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        err_d  = 1'b0;
        if (access && !FlushM) begin
          if (misaligned) begin
            misaligned_c = 1'b1;
          end else begin
            req_d.addr  = word_addr(AddrM);
            req_d.wstrb = MemWriteMaskM;
            req_d.wdata = WriteDataAlignedM;
            req_d.read  = MemReadM;
            cnt_d       = '0;
            stall_c     = 1'b1;
            state_d     = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        stall_c     = 1'b1;
        req_valid_c = 1'b1;
        cnt_d       = cnt_q + CNT_W'(1);
        kill_d      = kill_now;
        // An accepted request must be followed through, even on the last allowed cycle
        if (bus_req_ready) begin
          state_d = ST_WAIT;
        end else if (timeout_hit) begin
          if (kill_now) begin
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_DONE;
          end
        end
      end

      ST_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        kill_d  = kill_now;
        if (bus_rsp_valid) begin
          if (req_q.read && !kill_now) begin
            rdata_d = bus_rsp_rdata;
          end
          state_d = kill_now ? ST_IDLE : ST_DONE;
        end else if (timeout_hit) begin
          if (kill_now) begin
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        load_valid_c = req_q.read & ~err_q;
        bus_error_c  = err_q;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Reset masks every control output, including the combinational IDLE stall
  assign StallMem      = stall_c & ~RESET;
  assign LoadValidM    = load_valid_c & ~RESET;
  assign MisalignedM   = misaligned_c & ~RESET;
  assign BusErrorM     = bus_error_c & ~RESET;
  assign bus_req_valid = req_valid_c & ~RESET;
  assign bus_wstrb     = RESET ? 4'h0 : req_q.wstrb;
  assign bus_addr      = req_q.addr;
  assign bus_wdata     = req_q.wdata;
  assign ReadDataRaw   = rdata_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Bench for dmem_bus_bridge: directed and randomized accesses against a
// transaction-level model of stall length, bus payload and load/exception results.
module tb_dmem_bus_bridge;

  logic        clk;
  logic        rst1, rst2, sel;
  logic        mem_read, flush;
  logic [3:0]  mask;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        rdy, rspv;
  logic [31:0] rdat;

  logic        stall1, lv1, mis1, be1, rv1;
  logic [31:0] rdr1, baddr1, bwdata1;
  logic [3:0]  bstrb1;
  logic        stall2, lv2, mis2, be2, rv2;
  logic [31:0] rdr2, baddr2, bwdata2;
  logic [3:0]  bstrb2;

  logic        o_stall, o_lv, o_mis, o_be, o_rv;
  logic [31:0] o_rdr, o_baddr, o_bwdata;
  logic [3:0]  o_bstrb;

  int          n_vec, n_err;
  logic [31:0] rdr_m [2];

  dmem_bus_bridge u_dut (
    .CLK(clk), .RESET(rst1), .MemReadM(mem_read), .MemWriteMaskM(mask), .Funct3M(funct3),
    .AddrM(addr), .WriteDataAlignedM(wdata), .FlushM(flush), .StallMem(stall1),
    .ReadDataRaw(rdr1), .LoadValidM(lv1), .MisalignedM(mis1), .BusErrorM(be1),
    .bus_req_valid(rv1), .bus_req_ready(rdy), .bus_addr(baddr1), .bus_wstrb(bstrb1),
    .bus_wdata(bwdata1), .bus_rsp_valid(rspv), .bus_rsp_rdata(rdat)
  );

  dmem_bus_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(3)) u_dut_to (
    .CLK(clk), .RESET(rst2), .MemReadM(mem_read), .MemWriteMaskM(mask), .Funct3M(funct3),
    .AddrM(addr), .WriteDataAlignedM(wdata), .FlushM(flush), .StallMem(stall2),
    .ReadDataRaw(rdr2), .LoadValidM(lv2), .MisalignedM(mis2), .BusErrorM(be2),
    .bus_req_valid(rv2), .bus_req_ready(rdy), .bus_addr(baddr2), .bus_wstrb(bstrb2),
    .bus_wdata(bwdata2), .bus_rsp_valid(rspv), .bus_rsp_rdata(rdat)
  );

  assign o_stall  = sel ? stall2  : stall1;
  assign o_lv     = sel ? lv2     : lv1;
  assign o_mis    = sel ? mis2    : mis1;
  assign o_be     = sel ? be2     : be1;
  assign o_rv     = sel ? rv2     : rv1;
  assign o_rdr    = sel ? rdr2    : rdr1;
  assign o_baddr  = sel ? baddr2  : baddr1;
  assign o_bwdata = sel ? bwdata2 : bwdata1;
  assign o_bstrb  = sel ? bstrb2  : bstrb1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_bubble();
    mem_read = 1'b0; mask = 4'h0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    flush = 1'b0; rdy = 1'b0; rspv = 1'b0; rdat = 32'h0;
  endtask

  // One MEM-stage instruction, bus partner answering after rdy_dly/rsp_dly cycles
  // (rsp_dly < 0: never). flush_cyc: cycle index of a one-cycle FlushM (<0: none).
  task automatic run_access(input string tag, input logic rd, input logic [3:0] m,
                            input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd,
                            input int rdy_dly, input int rsp_dly, input logic [31:0] rword,
                            input int flush_cyc);
    int tmo, k_hs, k_rsp, rw, exp_stall, exp_req;
    logic acc, mis, go, to_req, to_any, killed, exp_lv, exp_be, exp_mis;
    int n_stall, n_lv, n_be, n_mis, n_req, first_req, done_cyc, bad_pay, vcnt, wcnt;
    logic present, hs, finished;
    logic [31:0] lv_data, be_data;

    tmo       = sel ? 4 : 255;
    acc       = rd | (|m);
    mis       = acc && ((int'(a[1:0]) % (1 << fn[1:0])) != 0);
    go        = acc && !mis && (flush_cyc != 0);
    k_hs      = rdy_dly + 1;
    to_req    = k_hs > tmo;
    k_rsp     = (rsp_dly < 0) ? 1000000 : k_hs + 1 + rsp_dly;
    to_any    = to_req || (k_rsp > tmo);
    rw        = to_any ? tmo : k_rsp;
    exp_req   = !go ? 0 : (to_req ? tmo : k_hs);
    exp_stall = go ? 1 + rw : 0;
    killed    = go && (flush_cyc > 0) && (flush_cyc <= rw);
    exp_lv    = go && rd && !to_any && !killed;
    exp_be    = go && to_any && !killed;
    exp_mis   = acc && mis && (flush_cyc != 0);

    n_stall = 0; n_lv = 0; n_be = 0; n_mis = 0; n_req = 0; first_req = -1; done_cyc = -1;
    bad_pay = 0; vcnt = 0; wcnt = 0; present = 1'b1; hs = 1'b0; finished = 1'b0;
    lv_data = 32'h0; be_data = 32'h0;

    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      mem_read = present ? rd : 1'b0;
      mask     = present ? m : 4'h0;
      funct3   = present ? fn : 3'b000;
      addr     = present ? a : 32'h0;
      wdata    = present ? wd : 32'h0;
      flush    = (c == flush_cyc);
      rdy = 1'b0; rspv = 1'b0; rdat = $urandom;
      #1;
      if (hs) begin
        if (wcnt == rsp_dly) begin rspv = 1'b1; rdat = rword; end
        wcnt++;
      end else if (o_rv) begin
        if (vcnt == rdy_dly) rdy = 1'b1;
        else rspv = 1'($urandom_range(0, 1));
        vcnt++;
      end
      #1;
      if (o_stall) n_stall++;
      if (o_mis) n_mis++;
      if (o_lv) begin n_lv++; lv_data = o_rdr; if (done_cyc < 0) done_cyc = c; end
      if (o_be) begin n_be++; be_data = o_rdr; if (done_cyc < 0) done_cyc = c; end
      if (o_rv) begin
        n_req++;
        if (first_req < 0) first_req = c;
        if (o_baddr !== {a[31:2], 2'b00} || o_bstrb !== m || o_bwdata !== wd) bad_pay++;
      end
      if (o_rv && rdy) hs = 1'b1;
      if (flush) present = 1'b0;
      if (!o_stall) begin finished = 1'b1; break; end
    end

    if (exp_lv) rdr_m[int'(sel)] = rword;
    else if (exp_be) rdr_m[int'(sel)] = 32'h0;

    chk({tag, "/bounded"}, 32'(finished), 32'd1);
    chk({tag, "/stall_cycles"}, 32'(n_stall), 32'(exp_stall));
    chk({tag, "/req_cycles"}, 32'(n_req), 32'(exp_req));
    chk({tag, "/first_req"}, 32'(first_req), go ? 32'd1 : 32'hffff_ffff);
    chk({tag, "/payload_stable"}, 32'(bad_pay), 32'd0);
    chk({tag, "/load_valid"}, 32'(n_lv), 32'(exp_lv));
    chk({tag, "/bus_error"}, 32'(n_be), 32'(exp_be));
    chk({tag, "/misaligned"}, 32'(n_mis), 32'(exp_mis));
    chk({tag, "/read_data_hold"}, o_rdr, rdr_m[int'(sel)]);
    if (exp_lv) chk({tag, "/load_data"}, lv_data, rword);
    if (exp_be) chk({tag, "/err_data"}, be_data, 32'h0);
    if (exp_lv || exp_be) chk({tag, "/done_cycle"}, 32'(done_cyc), 32'(1 + rw));
  endtask

  initial begin
    logic        r;
    logic [2:0]  fn;
    logic [3:0]  m;
    logic [31:0] a, wd, rw_word;
    int          sz, fc;

    n_vec = 0; n_err = 0;
    rdr_m[0] = 32'h0; rdr_m[1] = 32'h0;
    sel = 1'b0; rst1 = 1'b1; rst2 = 1'b1;
    drive_bubble();
    repeat (3) @(negedge clk);
    rst1 = 1'b0;
    #2;
    chk("reset/stall", 32'(o_stall), 32'd0);
    chk("reset/req_valid", 32'(o_rv), 32'd0);
    chk("reset/load_valid", 32'(o_lv), 32'd0);
    chk("reset/misaligned", 32'(o_mis), 32'd0);
    chk("reset/bus_error", 32'(o_be), 32'd0);
    chk("reset/wstrb", 32'(o_bstrb), 32'd0);
    chk("reset/read_data", o_rdr, 32'h0);

    run_access("lw_0x100", 1'b1, 4'h0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, -1);
    run_access("sb_0x203", 1'b0, 4'b1000, 3'b000, 32'h203, 32'hAB000000, 4, 0, 32'h0, -1);
    run_access("lh_0x101", 1'b1, 4'h0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0, -1);
    run_access("sw_0x102", 1'b0, 4'hF, 3'b010, 32'h102, 32'h11223344, 0, 0, 32'h0, -1);
    run_access("lw_flush_idle", 1'b1, 4'h0, 3'b010, 32'h104, 32'h0, 0, 0, 32'h55, 0);
    run_access("lw_flush_wait", 1'b1, 4'h0, 3'b010, 32'h300, 32'h0, 0, 2, 32'h12345678, 2);
    run_access("lbu_slow", 1'b1, 4'h0, 3'b100, 32'h7, 32'h0, 2, 3, 32'h000000A5, -1);

    for (int i = 0; i < 40; i++) begin
      r  = 1'($urandom_range(0, 1));
      a  = $urandom;
      wd = $urandom;
      rw_word = $urandom;
      sz = $urandom_range(0, 2);
      fn = 3'(sz);
      if (r && sz != 2 && $urandom_range(0, 1) == 1) fn[2] = 1'b1;
      m  = r ? 4'h0 : 4'((sz == 0 ? 4'b0001 : sz == 1 ? 4'b0011 : 4'b1111) << a[1:0]);
      if ($urandom_range(0, 9) == 0) begin r = 1'b0; m = 4'h0; end
      fc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_access("rand", r, m, fn, a, wd, int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)), rw_word, fc);
    end

    // Back-to-back loads, second one abandoned by RESET while waiting
    run_access("b2b_lw_0x0", 1'b1, 4'h0, 3'b010, 32'h0, 32'h0, 0, 0, 32'hC0FFEE01, -1);
    @(negedge clk);
    mem_read = 1'b1; mask = 4'h0; funct3 = 3'b010; addr = 32'h4; wdata = 32'h0;
    flush = 1'b0; rdy = 1'b0; rspv = 1'b0;
    #2;
    chk("b2b/idle_stall", 32'(o_stall), 32'd1);
    chk("b2b/idle_no_req", 32'(o_rv), 32'd0);
    @(negedge clk);
    rdy = 1'b1;
    #2;
    chk("b2b/req_valid", 32'(o_rv), 32'd1);
    chk("b2b/req_addr", o_baddr, 32'h4);
    @(negedge clk);
    rdy = 1'b0;
    #2;
    chk("b2b/wait_stall", 32'(o_stall), 32'd1);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    drive_bubble();
    #2;
    chk("rst_mid/stall", 32'(o_stall), 32'd0);
    chk("rst_mid/req_valid", 32'(o_rv), 32'd0);
    chk("rst_mid/load_valid", 32'(o_lv), 32'd0);
    chk("rst_mid/bus_error", 32'(o_be), 32'd0);
    chk("rst_mid/wstrb", 32'(o_bstrb), 32'd0);
    chk("rst_mid/read_data", o_rdr, 32'h0);
    rdr_m[0] = 32'h0;
    rspv = 1'b1; rdat = 32'hBAD0BAD0;
    @(negedge clk);
    rspv = 1'b0;
    #2;
    chk("rst_mid/late_rsp_lv", 32'(o_lv), 32'd0);
    chk("rst_mid/late_rsp_stall", 32'(o_stall), 32'd0);
    chk("rst_mid/late_rsp_data", o_rdr, 32'h0);

    // Short-timeout instance
    rst1 = 1'b1; rst2 = 1'b0; sel = 1'b1;
    run_access("to_good_lw", 1'b1, 4'h0, 3'b010, 32'h40, 32'h0, 0, 0, 32'hCAFEF00D, -1);
    run_access("to_wait", 1'b1, 4'h0, 3'b010, 32'h44, 32'h0, 0, -1, 32'h0, -1);
    run_access("to_idle_after", 1'b1, 4'h0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0, -1);
    run_access("to_good_lw2", 1'b1, 4'h0, 3'b010, 32'h48, 32'h0, 1, 0, 32'h600DD00D, -1);
    run_access("to_req", 1'b0, 4'hF, 3'b010, 32'h4C, 32'h99887766, 10, 0, 32'h0, -1);

    @(negedge clk);
    drive_bubble();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- MEM-stage bridge between the load/store alignment logic and a valid/ready data-memory bus.
- Takes the byte-lane write mask, the lane-aligned write data and the effective address produced in MEM.
- Issues one bus transaction per access, stalls the pipeline until the response arrives, and returns the raw 32-bit word for load extension.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in REQ+WAIT before the access is abandoned with a bus error; must be ≥2.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- MemReadM  in  1  MEM-stage instruction is a load.
- MemWriteMaskM  in  4  byte-lane write mask, already shifted by the address offset; nonzero means store.
- Funct3M  in  3  access size (000/100 byte, 001/101 half, 010 word).
- AddrM  in  32  effective byte address.
- WriteDataAlignedM  in  32  lane-aligned store data.
- FlushM  in  1  kill the MEM-stage instruction.
- StallMem  out  1  freeze IF..MEM stages.
- ReadDataRaw  out  32  raw memory word, passed on for shifting and sign/zero extension.
- LoadValidM  out  1  ReadDataRaw valid this cycle.
- MisalignedM  out  1  misaligned access exception.
- BusErrorM  out  1  timeout exception.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  request accepted.
- bus_addr  out  32  word address, {AddrM[31:2],2'b00}.
- bus_wstrb  out  4  write strobes; 0 means read.
- bus_wdata  out  32  write data.
- bus_rsp_valid  in  1  response valid.
- bus_rsp_rdata  in  32  read data; don't-care for writes.

Behaviour:
- Access = MemReadM | (|MemWriteMaskM).
- Misaligned = Access & ((size half & AddrM[0]) | (size word & AddrM[1:0]≠0)).
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If Access & !Misaligned & !FlushM: capture AddrM, MemWriteMaskM, WriteDataAlignedM and MemReadM into request registers; assert StallMem combinationally; go to REQ.
  - If Access & Misaligned & !FlushM: MisalignedM=1 for this cycle only, no bus activity, no stall, stay in IDLE.
  - FlushM in IDLE suppresses everything.
- REQ:
  - bus_req_valid=1 with the registered addr/wstrb/wdata, held stable until bus_req_ready.
  - On ready go to WAIT. StallMem=1.
- WAIT:
  - StallMem=1.
  - On bus_rsp_valid: capture bus_rsp_rdata (reads only; writes capture nothing) and go to DONE.
  - A response in the same cycle as acceptance is not allowed; the earliest legal response is the cycle after the handshake.
  - bus_rsp_valid in any state other than WAIT is ignored.
- DONE:
  - StallMem=0; LoadValidM=1 if the request was a read; ReadDataRaw holds the captured word.
  - Return to IDLE next cycle, where the next instruction is evaluated.
- Minimum stall with a zero-wait bus: 3 cycles (IDLE, REQ, WAIT), then DONE.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - At TIMEOUT_CYCLES go to DONE with BusErrorM=1 (one cycle), ReadDataRaw=0 and LoadValidM=0.
  - If this happens in REQ, bus_req_valid drops.
- FlushM while in REQ/WAIT:
  - Set a sticky kill flag. The transaction still completes, because a bus transaction cannot be cancelled.
  - On completion go directly to IDLE, skipping DONE: no LoadValidM and no BusErrorM.
  - StallMem still asserts until completion.
- ReadDataRaw holds its value outside DONE; it updates only on a read capture or timeout.
- Reset (synchronous): state=IDLE, counter=0, kill=0, request registers=0, ReadDataRaw=0.
- Reset forces all outputs low: StallMem, LoadValidM, MisalignedM, BusErrorM, bus_req_valid; bus_wstrb=0.
- RESET mid-transaction abandons it immediately; the bus partner is reset by the same RESET.

Decomposition:
- Shared package:
  - FSM state encoding (2 bits).
  - Funct3 size codes (BYTE/HALF/WORD and unsigned variants).
  - Exception cause codes for load/store misaligned and load/store access fault, consumed by the trap logic.
- One natural sub-module, dmem_align_check: the combinational size/offset misalignment detector. It is reusable by a future AMO path.
- FSM, request registers and timeout counter stay in the top module.

Test Plan:
- LW at 0x100, bus ready immediately, rsp one cycle later with 0xDEADBEEF:
  - StallMem high for exactly 3 cycles; bus_addr=0x100, bus_wstrb=0.
  - DONE cycle: LoadValidM=1, ReadDataRaw=0xDEADBEEF.
- SB at 0x203 with mask 4'b1000 and data 0xAB000000, ready held low for 4 cycles:
  - bus_req_valid and payload stable for all 5 REQ cycles; bus_wstrb=4'b1000, bus_addr=0x200.
  - LoadValidM never asserted.
- LH at 0x101:
  - MisalignedM=1 for one cycle, StallMem=0, bus_req_valid never asserted.
  - Same for SW at 0x102.
- Load with TIMEOUT_CYCLES=4 and bus_rsp_valid never asserted:
  - BusErrorM=1 exactly once, ReadDataRaw=0, LoadValidM=0; FSM back in IDLE next cycle.
- FlushM pulsed in WAIT, response 0x12345678 two cycles later:
  - No LoadValidM; ReadDataRaw unchanged.
  - StallMem drops the cycle after the response.
- Back-to-back LW 0x0 then LW 0x4:
  - Second request issued the cycle after DONE.
  - RESET asserted during the second WAIT returns all outputs to 0 next edge, with no LoadValidM.
